// File: rtl/alu_pkg.sv
// Shared opcodes, sequencer state encoding and command entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    // ALU opcodes as seen on alu_code / res_code
    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_NOT  = 3'd2;
    localparam logic [2:0] OP_MUL  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_OR   = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_NOR  = 3'd7;

    // Width of one queued command {chain, a, b, code}
    localparam int CMD_W = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_OUT   = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic       chain;
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] code;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signal bundle of the ALU command sequencer.
// Latency: n/a (wiring only).
// Backpressure: cmd_ready and res_ready carry valid/ready flow control.
interface alu_cmd_sequencer_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_code;
    logic       cmd_chain;

    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_code;
    logic       alu_en;
    logic [7:0] alu_result;

    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic [2:0] res_code;
    logic       res_zero;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_code, cmd_chain,
        output cmd_ready,
        output alu_a, alu_b, alu_code, alu_en,
        input  alu_result,
        output res_valid, res_data, res_code, res_zero,
        input  res_ready
    );

    // Command producer, ALU and result consumer side
    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_code, cmd_chain,
        input  cmd_ready,
        input  alu_a, alu_b, alu_code, alu_en,
        output alu_result,
        input  res_valid, res_data, res_code, res_zero,
        output res_ready
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO, no fall-through, registered full/empty flags.
// Latency: an entry pushed at edge T is visible on pop_dat / empty=0 after edge T.
// Backpressure: push ignored while full; full reads 1 during reset so nothing is taken in.
module alu_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         full,
    output logic         empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   count_nxt;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged
    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // Pointers, occupancy and flags; flags registered from next occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b1;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

    // Entry storage; contents are don't-care while empty so no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, drives the ALU one command at a time and holds each result for a valid/ready consumer.
// Latency: command accepted at edge T into an idle empty block -> alu_en in T+1..T+2 -> res_valid after T+2.
// Backpressure: res_ready low parks the result in OUT; DEPTH more commands queue, then cmd_ready drops.
module alu_cmd_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_cmd_sequencer_if.slave bus
);

    seq_state_t state;
    cmd_t       in_cmd;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       load_next;
    logic [3:0] load_a;
    logic [3:0] last_lo;

    logic [3:0] alu_a_q;
    logic [3:0] alu_b_q;
    logic [2:0] alu_code_q;
    logic       alu_en_q;
    logic       res_valid_q;
    logic [7:0] res_data_q;
    logic [2:0] res_code_q;
    logic       res_zero_q;

    assign in_cmd = '{chain: bus.cmd_chain, a: bus.cmd_a, b: bus.cmd_b, code: bus.cmd_code};

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (CMD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (bus.cmd_valid),
        .push_dat (in_cmd),
        .pop      (load_next),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Pop whenever the ALU is free to take a command: idle, or the held result is being consumed
    assign load_next = !fifo_empty &&
                       ((state == ST_IDLE) || ((state == ST_OUT) && bus.res_ready));

    // Chained commands take A from the most recent result, even if it is still parked in OUT
    assign load_a = head.chain ? last_lo : head.a;

    assign bus.cmd_ready = !fifo_full;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;
    assign bus.alu_code  = alu_code_q;
    assign bus.alu_en    = alu_en_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_code  = res_code_q;
    assign bus.res_zero  = res_zero_q;

    // Issue FSM: load operands, pulse alu_en for the DRIVE cycle, capture and hold the result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_code_q  <= '0;
            alu_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_code_q  <= '0;
            res_zero_q  <= 1'b1;
            last_lo     <= '0;
        end else begin
            alu_en_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_next) begin
                        alu_a_q    <= load_a;
                        alu_b_q    <= head.b;
                        alu_code_q <= head.code;
                        alu_en_q   <= 1'b1;
                        state      <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    // Only cycle in which alu_result is meaningful
                    res_data_q  <= bus.alu_result;
                    res_code_q  <= alu_code_q;
                    res_zero_q  <= (bus.alu_result == 8'd0);
                    last_lo     <= bus.alu_result[3:0];
                    res_valid_q <= 1'b1;
                    state       <= ST_OUT;
                end
                ST_OUT: begin
                    if (bus.res_ready) begin
                        // Result consumed; drop valid so it cannot be taken twice
                        res_valid_q <= 1'b0;
                        if (load_next) begin
                            alu_a_q    <= load_a;
                            alu_b_q    <= head.b;
                            alu_code_q <= head.code;
                            alu_en_q   <= 1'b1;
                            state      <= ST_DRIVE;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer with a behavioural ALU and a queue-based scoreboard.
// Latency: n/a.
// Backpressure: res_ready driven directed and random.
module tb_alu_cmd_sequencer;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   acc_cnt;
    int   res_cnt;
    int   cyc;
    int   last_hs;
    logic have_last;
    logic chk_gap;
    logic pend_en;
    logic [7:0] model_last;
    logic [3:0] eff_a;
    logic [7:0] eff_r;

    typedef struct {
        logic [7:0] data;
        logic [2:0] code;
    } exp_t;

    exp_t exp_q[$];
    exp_t head_e;

    alu_cmd_sequencer_if bus();

    alu_cmd_sequencer #(.DEPTH(4), .AW(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ALU arithmetic from the opcode table
    function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [2:0] code);
        logic [7:0] xa;
        logic [7:0] xb;
        xa = {4'd0, a};
        xb = {4'd0, b};
        case (code)
            OP_ADD:  return xa + xb;
            OP_SUB:  return xa - xb;
            OP_NOT:  return ~xa;
            OP_MUL:  return xa * xb;
            OP_AND:  return xa & xb;
            OP_OR:   return xa | xb;
            OP_NAND: return ~(xa & xb);
            default: return ~(xa | xb);
        endcase
    endfunction

    // Stand-in for the existing ALU; junk on the bus while disabled exposes stray sampling
    always_comb begin
        bus.alu_result = bus.alu_en ? alu_ref(bus.alu_a, bus.alu_b, bus.alu_code) : 8'hA5;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acceptance monitor: every accepted command produces one expected result
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_last = 8'd0;
        end else if (bus.cmd_valid && bus.cmd_ready) begin
            eff_a      = bus.cmd_chain ? model_last[3:0] : bus.cmd_a;
            eff_r      = alu_ref(eff_a, bus.cmd_b, bus.cmd_code);
            model_last = eff_r;
            exp_q.push_back('{data: eff_r, code: bus.cmd_code});
            acc_cnt++;
        end
    end

    // Result monitor: compare each consumed result in order; police the alu_en pulse
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_en = 1'b0;
        end else begin
            if (pend_en) begin
                chk("en_one_cycle", 32'(bus.alu_en), 32'd0);
                chk("en_then_valid", 32'(bus.res_valid), 32'd1);
            end
            pend_en = bus.alu_en;
            if (bus.res_valid && bus.res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("res_unexpected", 32'(bus.res_data), 32'hFFFF_FFFF);
                end else begin
                    head_e = exp_q.pop_front();
                    chk("res_data", 32'(bus.res_data), 32'(head_e.data));
                    chk("res_code", 32'(bus.res_code), 32'(head_e.code));
                    chk("res_zero", 32'(bus.res_zero), 32'(head_e.data == 8'd0));
                    res_cnt++;
                    if (chk_gap && have_last) begin
                        chk("res_gap", 32'(cyc - last_hs), 32'd2);
                    end
                    last_hs   = cyc;
                    have_last = 1'b1;
                end
            end
        end
    end

    task automatic send(input logic ch, input logic [3:0] a, input logic [3:0] b, input logic [2:0] code);
        int   n;
        logic acc;
        n             = 0;
        acc           = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_chain = ch;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_code  = code;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.cmd_ready && rst_n;
            tick();
            n++;
        end
        bus.cmd_valid = 1'b0;
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic rand_fields();
        bus.cmd_chain = 1'($urandom_range(0, 1));
        bus.cmd_a     = 4'($urandom_range(0, 15));
        bus.cmd_b     = 4'($urandom_range(0, 15));
        bus.cmd_code  = 3'($urandom_range(0, 7));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.res_valid) && n < 300) begin
            tick();
            n++;
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int base;
        int ghost;
        vectors       = 0;
        miscompares   = 0;
        acc_cnt       = 0;
        res_cnt       = 0;
        cyc           = 0;
        last_hs       = 0;
        have_last     = 1'b0;
        chk_gap       = 1'b0;
        pend_en       = 1'b0;
        model_last    = 8'd0;
        rst_n         = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        bus.cmd_chain = 1'b0;
        bus.cmd_a     = 4'd0;
        bus.cmd_b     = 4'd0;
        bus.cmd_code  = 3'd0;

        // Reset values
        repeat (3) tick();
        @(negedge clk);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_alu_a", 32'(bus.alu_a), 32'd0);
        chk("rst_alu_b", 32'(bus.alu_b), 32'd0);
        chk("rst_alu_code", 32'(bus.alu_code), 32'd0);
        chk("rst_alu_en", 32'(bus.alu_en), 32'd0);
        chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
        chk("rst_res_data", 32'(bus.res_data), 32'd0);
        chk("rst_res_code", 32'(bus.res_code), 32'd0);
        chk("rst_res_zero", 32'(bus.res_zero), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        tick();

        // Single add: latency and one-cycle enable
        bus.res_ready = 1'b1;
        send(1'b0, 4'd10, 4'd11, OP_ADD);
        @(negedge clk);
        chk("lat_idle_en", 32'(bus.alu_en), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_drive_en", 32'(bus.alu_en), 32'd1);
        chk("lat_drive_valid", 32'(bus.res_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_out_en", 32'(bus.alu_en), 32'd0);
        chk("lat_out_valid", 32'(bus.res_valid), 32'd1);
        tick();
        wait_drain();

        // Back-to-back results, one every two cycles
        base      = res_cnt;
        have_last = 1'b0;
        chk_gap   = 1'b1;
        send(1'b0, 4'd3, 4'd5, OP_SUB);
        send(1'b0, 4'd10, 4'd0, OP_NOT);
        send(1'b0, 4'd15, 4'd15, OP_MUL);
        send(1'b0, 4'd15, 4'd15, OP_NOR);
        wait_drain();
        chk_gap = 1'b0;
        chk("b2b_count", 32'(res_cnt - base), 32'd4);

        // Zero flag, then chain from the zero result
        send(1'b0, 4'd10, 4'd5, OP_AND);
        send(1'b1, 4'd9, 4'd1, OP_ADD);
        wait_drain();

        // Capacity: DEPTH+1 accepted with res_ready low
        bus.res_ready = 1'b0;
        base          = acc_cnt;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            rand_fields();
            tick();
        end
        @(negedge clk);
        chk("cap_accepted", 32'(acc_cnt - base), 32'd5);
        chk("cap_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("cap_res_valid", 32'(bus.res_valid), 32'd1);
        chk("cap_res_hold", 32'(bus.res_data), 32'(exp_q[0].data));
        tick();
        bus.res_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("cap_ready_back", 32'(bus.cmd_ready), 32'd1);
        tick();
        bus.cmd_valid = 1'b0;
        wait_drain();
        chk("cap_total", 32'(acc_cnt - base), 32'd6);

        // Reset during DRIVE with three commands queued
        bus.res_ready = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            tick();
        end
        bus.cmd_valid = 1'b0;
        tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        chk("mid_in_drive", 32'(bus.alu_en), 32'd1);
        chk("mid_queued", 32'(u_dut.u_fifo.count), 32'd3);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_res_valid", 32'(bus.res_valid), 32'd0);
        chk("mid_alu_en", 32'(bus.alu_en), 32'd0);
        chk("mid_cmd_ready_rst", 32'(bus.cmd_ready), 32'd0);
        tick();
        @(negedge clk);
        chk("mid_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.res_ready = 1'b1;
        ghost = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            if (bus.alu_en || bus.res_valid) ghost++;
        end
        chk("mid_no_ghost", 32'(ghost), 32'd0);
        chk("mid_queue_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // Simultaneous push and pop at occupancy 2
        bus.res_ready = 1'b0;
        send(1'b0, 4'd1, 4'd2, OP_ADD);
        send(1'b0, 4'd7, 4'd3, OP_OR);
        send(1'b1, 4'd0, 4'd6, OP_NAND);
        bus.cmd_valid = 1'b1;
        bus.cmd_chain = 1'b0;
        bus.cmd_a     = 4'd12;
        bus.cmd_b     = 4'd4;
        bus.cmd_code  = OP_SUB;
        bus.res_ready = 1'b1;
        tick();
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b0;
        @(negedge clk);
        chk("pp_count", 32'(u_dut.u_fifo.count), 32'd2);
        tick();
        bus.res_ready = 1'b1;
        wait_drain();

        // Random traffic with backpressure and occasional reset
        for (int i = 0; i < 600; i++) begin
            bus.cmd_valid = ($urandom_range(0, 99) < 60);
            rand_fields();
            bus.res_ready = ($urandom_range(0, 99) < 55);
            rst_n         = ($urandom_range(0, 249) != 0);
            tick();
        end
        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream issue stage for the 4-bit ALU (a, b, code, en → aluout[7:0]). It buffers operand/opcode commands in a small FIFO and drives the ALU one command at a time. It asserts the ALU enable for exactly one cycle per command, captures the 8-bit result and presents it on a valid/ready result port. It also supports chaining, where operand A is taken from the previous result.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at clk edge
cmd_a  input  4  operand A
cmd_b  input  4  operand B
cmd_code  input  3  ALU opcode (0 add,1 sub,2 not A,3 mul,4 and,5 or,6 nand,7 nor)
cmd_chain  input  1  1: use last_result[3:0] as A, ignore cmd_a
alu_a  output  4  to ALU a
alu_b  output  4  to ALU b
alu_code  output  3  to ALU code
alu_en  output  1  to ALU en
alu_result  input  8  from ALU aluout
res_valid  output  1  result available
res_ready  input  1  result consumed when res_valid&res_ready at clk edge
res_data  output  8  captured result
res_code  output  3  opcode that produced res_data
res_zero  output  1  res_data == 0

Behaviour:
- Clock/reset decided: single clock clk; reset rst_n is synchronous, active-low; sampled only on rising clk.
- Reset values: cmd_ready=0 during reset, 1 the first cycle after. alu_a=0, alu_b=0, alu_code=0, alu_en=0, res_valid=0, res_data=0, res_code=0, res_zero=1. FIFO empty, last_result=0, FSM=IDLE.
- FIFO: cmd_ready = !full (registered count). Stored entry = {chain,a,b,code}. No fall-through: a command pushed at edge T is poppable from edge T+1.
- FSM states: IDLE, DRIVE, OUT.
  - IDLE: if FIFO non-empty → pop at edge and load alu_a/b/code → DRIVE. With chain=1, alu_a is loaded from last_result[3:0].
  - DRIVE: alu_en=1 for exactly this one cycle. At the edge, capture res_data=alu_result, res_code=alu_code, res_zero=(alu_result==0), last_result=alu_result, res_valid←1 → OUT.
  - OUT: res_valid held; res_data/res_code/res_zero stable until handshake. On res_valid&res_ready: if FIFO non-empty, pop and load ALU inputs → DRIVE (back-to-back); else res_valid←0 → IDLE.
- alu_en=0 in IDLE and OUT (ALU output Z). alu_result is never sampled outside DRIVE. alu_a/b/code hold their last loaded value when not in DRIVE.
- Latency: command accepted at edge T into an idle, empty block → alu_en high in cycle T+1..T+2 → res_valid high after edge T+2.
- Throughput: one result per 2 cycles with res_ready tied high.
- Chain uses last_result at pop time, i.e. the most recently captured result, even if it is still held in OUT.
- Capacity: 1 result in OUT plus DEPTH in FIFO. With res_ready=0, DEPTH+1 commands are accepted before cmd_ready falls.
- Simultaneous push and pop in the same cycle is allowed when not full; count is unchanged. A push while full is impossible (cmd_ready=0).
- Reset mid-operation (any state): next edge goes to reset values. FIFO contents and any pending result are discarded; alu_en drops in the same edge.
- Width rules: res_data is the full 8-bit ALU result, no truncation. Chain uses the low nibble only.

Decomposition:
- Shared package alu_pkg: opcode localparams OP_ADD..OP_NOR (3'd0..3'd7), FSM state encoding (2-bit), command entry width CMD_W=12.
- One sub-module: alu_cmd_fifo (synchronous FIFO, DEPTH/AW params, full/empty/count, registered outputs). The sequencer instantiates it; the bench also connects the existing ALU to alu_a/b/code/en/result.

Test Plan:
- After reset, push {a=10,b=11,code=0} with res_ready=1 → alu_en high exactly one cycle, res_valid after 2 edges, res_data=0x15, res_zero=0.
- Back-to-back: sub 3-5, not 10, mul 15*15, nor 15,15 → results 0xFE, 0xF5, 0xE1, 0xF0 in order, one every 2 cycles, res_code matching.
- AND a=10,b=5 → res_data=0x00, res_zero=1. Then chain add b=1 (cmd_a=9 ignored) → res_data=0x01.
- res_ready=0, push 6 commands → 5 accepted, cmd_ready low on 6th; res_data stable. Release res_ready → all 5 results in order, cmd_ready returns after first pop.
- Assert rst_n=0 for one cycle while in DRIVE with 3 queued → next cycle res_valid=0, alu_en=0, cmd_ready=1, no queued command ever executes.
- Push and pop in the same cycle with FIFO at count 2 → count stays 2, no loss or duplication (scoreboard check).
